// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares the 16-word register RAM between instruction fetch
//                (port 0) and data load/store (port 1). Round-robin by
//                default; define ARB_FIXED_PRIO_EN for fixed port-0 priority.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [0:3]    addr0,
    input  logic [0:3]    addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [0:3]    adress,
    output logic          enram,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_port;
    logic            r_we;
    logic [0:3]      r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_done0;
    logic            r_done1;
    logic            w_win;
    logic            w_load;

    // w_win: index of the port that would win arbitration right now
`ifdef ARB_FIXED_PRIO_EN
    assign w_win = ~req0;
`else
    logic r_last;

    assign w_win = (req0 && req1) ? ~r_last : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (r_state == ST_ACCESS) begin
            r_last <= r_port;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Chain straight into the other port only if it wins arbitration
                if ((req0 || req1) && (w_win != r_port)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 4'b0000;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_load) begin
                r_port  <= w_win;
                r_we    <= w_win ? we1 : we0;
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
            end
            if (r_state == ST_ACCESS) begin
                r_done0 <= ~r_port;
                r_done1 <= r_port;
                if (!r_we) begin
                    r_rdata <= ram_rdata;
                end
            end
        end
    end

    // Grant is asserted in the cycle the request is accepted; masked in reset
    assign gnt0      = reset_n & w_load & ~w_win;
    assign gnt1      = reset_n & w_load & w_win;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign rdata     = r_rdata;
    assign enram     = (r_state == ST_ACCESS);
    assign adress    = enram ? r_addr : 4'b0000;
    assign ram_we    = enram & r_we;
    assign ram_wdata = enram ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed self-checking bench for ram_arbiter with a
//                behavioural 16-word RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [0:3]    addr0, addr1, adress;
    logic [DW-1:0] wdata0, wdata1, rdata, ram_wdata, ram_rdata;
    logic          gnt0, gnt1, done0, done1, enram, ram_we;

    logic [DW-1:0] mem [16];
    logic          preload = 1'b1;
    logic [9:0]    both_exp [9];
    int            checks   = 0;
    int            failures = 0;

    ram_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .adress    (adress),
        .enram     (enram),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return 8'(i * 19) ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= pat(i);
        end else if (enram && ram_we) begin
            mem[adress] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[adress];

    function automatic logic [9:0] v(input logic g0, input logic g1, input logic d0,
                                     input logic d1, input logic en, input logic we,
                                     input logic [3:0] a);
        return {g0, g1, d0, d1, en, we, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [9:0] exp);
        chk(tag, {22'd0, gnt0, gnt1, done0, done1, enram, ram_we, adress}, {22'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        both_exp = '{v(1,0,0,0,0,0,0), v(0,0,0,0,1,0,1), v(0,0,1,0,0,0,0),
                     v(1,0,0,0,0,0,0), v(0,0,0,0,1,0,1), v(0,0,1,0,0,0,0),
                     v(1,0,0,0,0,0,0), v(0,0,0,0,1,0,1), v(0,0,1,0,0,0,0)};
`else
        both_exp = '{v(0,1,0,0,0,0,0), v(0,0,0,0,1,0,2), v(1,0,0,1,0,0,0),
                     v(0,0,0,0,1,0,1), v(0,1,1,0,0,0,0), v(0,0,0,0,1,0,2),
                     v(1,0,0,1,0,0,0), v(0,0,0,0,1,0,1), v(0,0,1,0,0,0,0)};
`endif
        reset_n = 1'b0;
        req0 = 1'b1;  req1 = 1'b1;
        we0  = 1'b0;  we1  = 1'b0;
        addr0 = 4'h3; addr1 = 4'h9;
        wdata0 = '0;  wdata1 = '0;

        // Reset with both ports requesting
        #3;
        outs("rst_outs", v(0,0,0,0,0,0,0));
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        cyc(); cyc();
        preload = 1'b0;
        #1 outs("rst_hold", v(0,0,0,0,0,0,0));
        cyc(); reset_n = 1'b1;
        #1 outs("rel_gnt0", v(1,0,0,0,0,0,0));
        cyc();
        #1 outs("rel_acc0", v(0,0,0,0,1,0,3));
        cyc(); req0 = 1'b0;
        #1 outs("rel_done0", v(0,1,1,0,0,0,0));
        chk("rel_rdata0", rdata, pat(3));
        cyc();
        #1 outs("rel_acc1", v(0,0,0,0,1,0,9));
        cyc(); req1 = 1'b0;
        #1 outs("rel_done1", v(0,0,0,1,0,0,0));
        chk("rel_rdata1", rdata, pat(9));
        cyc();
        #1 outs("rel_idle", v(0,0,0,0,0,0,0));

        // Port 1 sweeps all 16 words
        for (int i = 0; i < 16; i++) begin
            cyc(); req1 = 1'b1; addr1 = 4'(i);
            #1 outs("sweep_gnt", v(0,1,0,0,0,0,0));
            cyc();
            #1 outs("sweep_acc", v(0,0,0,0,1,0,4'(i)));
            cyc(); req1 = 1'b0;
            #1 outs("sweep_done", v(0,0,0,1,0,0,0));
            chk("sweep_rdata", rdata, pat(i));
        end

        // Port 0 write then read back the same word
        cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 4'b1010; wdata0 = 8'hA5;
        #1 outs("wr_gnt", v(1,0,0,0,0,0,0));
        cyc();
        #1 outs("wr_acc", v(0,0,0,0,1,1,4'hA));
        chk("wr_ram_wdata", ram_wdata, 8'hA5);
        cyc(); we0 = 1'b0; wdata0 = '0;
        #1 outs("wr_done", v(0,0,1,0,0,0,0));
        chk("wr_rdata_kept", rdata, pat(15));
        chk("wr_mem", mem[10], 8'hA5);
        cyc();
        #1 outs("rd_gnt", v(1,0,0,0,0,0,0));
        cyc();
        #1 outs("rd_acc", v(0,0,0,0,1,0,4'hA));
        chk("rd_ram_wdata", ram_wdata, 0);
        cyc(); req0 = 1'b0;
        #1 outs("rd_done", v(0,0,1,0,0,0,0));
        chk("rd_rdata", rdata, 8'hA5);

        // Both ports requesting continuously
        cyc(); req0 = 1'b1; req1 = 1'b1; addr0 = 4'h1; addr1 = 4'h2;
        #1 outs("both_0", both_exp[0]);
        for (int k = 1; k < 8; k++) begin
            cyc();
            #1 outs("both_k", both_exp[k]);
        end
        cyc(); req0 = 1'b0; req1 = 1'b0;
        #1 outs("both_8", both_exp[8]);
        chk("both_rdata", rdata, pat(1));

        // req1 pulsed during port 0 access and withdrawn
        cyc(); req0 = 1'b1; addr0 = 4'h5;
        #1 outs("wd_gnt0", v(1,0,0,0,0,0,0));
        cyc(); req1 = 1'b1;
        #1 outs("wd_acc", v(0,0,0,0,1,0,5));
        cyc(); req0 = 1'b0; req1 = 1'b0;
        #1 outs("wd_done0", v(0,0,1,0,0,0,0));
        chk("wd_rdata", rdata, pat(5));
        cyc();
        #1 outs("wd_idle", v(0,0,0,0,0,0,0));

        // Reset asserted during the access cycle of a port 1 write
        cyc(); req1 = 1'b1; we1 = 1'b1; addr1 = 4'h7; wdata1 = 8'h3C;
        #1 outs("ra_gnt1", v(0,1,0,0,0,0,0));
        cyc();
        #1 outs("ra_acc", v(0,0,0,0,1,1,7));
        chk("ra_ram_wdata", ram_wdata, 8'h3C);
        #1 reset_n = 1'b0;
        #1 outs("ra_drop", v(0,0,0,0,0,0,0));
        chk("ra_ram_wdata0", ram_wdata, 0);
        cyc();
        #1 outs("ra_no_done", v(0,0,0,0,0,0,0));
        chk("ra_mem", mem[7], pat(7));
        req1 = 1'b0; we1 = 1'b0;
        cyc(); reset_n = 1'b1;
        #1 outs("ra_idle", v(0,0,0,0,0,0,0));
        cyc(); req0 = 1'b1; req1 = 1'b1;
        #1 outs("ra_first_gnt0", v(1,0,0,0,0,0,0));
        cyc(); req1 = 1'b0;
        #1 outs("ra_acc0", v(0,0,0,0,1,0,5));
        cyc(); req0 = 1'b0;
        #1 outs("ra_done0", v(0,0,1,0,0,0,0));
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
